// File: rtl/riscv_axil_master_pkg.sv
// ---------------------------------------------------------------------------
// riscv_axil_master_pkg
// Shared types and constants for the AXI4-Lite single-beat master:
//   state_e        - transaction FSM states
//   RESP_*         - AXI response encodings (passed through unchanged)
//   is_xfer_state  - true while a bus transaction is in flight, i.e. the
//                    states in which the watchdog is allowed to count
// ---------------------------------------------------------------------------
package riscv_axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic is_xfer_state(input state_e s);
        return (s == WR_AW_W) || (s == WR_B) || (s == RD_AR) || (s == RD_R);
    endfunction

endpackage

// File: rtl/riscv_axil_master_if.sv
// ---------------------------------------------------------------------------
// riscv_axil_master_if
// AXI4-Lite bus bundle between the master and a control-register slave.
// Parameters: ADDR_W (byte address width), DATA_W (data width, strobe DATA_W/8).
// Signals (lower-case form of the M_AXI_* names):
//   AW: awaddr, awprot, awvalid / awready
//   W : wdata, wstrb, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: araddr, arprot, arvalid / arready
//   R : rdata, rresp, rvalid / rready
// Modports: master (initiator side), slave (target side).
// ---------------------------------------------------------------------------
interface riscv_axil_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/riscv_axil_master_watchdog.sv
// ---------------------------------------------------------------------------
// riscv_axil_master_watchdog
// Saturating cycle counter with a sticky expiry flag.
// Parameter: TIMEOUT_CYCLES - number of enabled cycles before expiry; 0 disables.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart: counter and flag to 0 (has priority over enable)
//   enable   in   count this cycle
//   expired  out  sticky; set once TIMEOUT_CYCLES enabled cycles have elapsed
// ---------------------------------------------------------------------------
module riscv_axil_master_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // +2 keeps the width >= 1 for TIMEOUT_CYCLES of 0 and lets the counter
    // hold the value TIMEOUT_CYCLES itself, where it parks.
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] count_q;
    logic          expired_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == LIMIT) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clear) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (enable && ENABLED) begin
            count_q <= sat_inc(count_q);
            // The cycle holding count LIMIT-1 is the LIMIT-th enabled cycle.
            if (count_q == LIMIT - CW'(1)) begin
                expired_q <= 1'b1;
            end
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/riscv_axil_master.sv
// ---------------------------------------------------------------------------
// riscv_axil_master
// AXI4-Lite single-beat master. Accepts one read or write command on a
// valid/ready stream, runs it as AW/W/B or AR/R on the bus, and returns the
// read data and response on a valid/ready response stream. One transaction
// outstanding; the next command is only accepted after the response has
// been consumed. A watchdog flags a slave that stalls a transaction.
// Parameters:
//   C_M_AXI_ADDR_WIDTH  byte address width
//   C_M_AXI_DATA_WIDTH  data width (strobe width DATA/8)
//   TIMEOUT_CYCLES      watchdog limit in cycles, 0 disables
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN         clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write, cmd_addr, cmd_wdata,
//   cmd_wstrb                         command payload (data/strobe unused for reads)
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_resp, rsp_write    response payload (rdata 0 for writes)
//   busy                              not idle
//   timeout                           sticky watchdog flag, cleared on next accept
//   m_axi                             AXI4-Lite master bus
// ---------------------------------------------------------------------------
module riscv_axil_master
    import riscv_axil_master_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_write,

    output logic                            busy,
    output logic                            timeout,

    riscv_axil_master_if.master             m_axi
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q;
    state_e                          state_d;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]               wstrb_q;
    logic                            write_q;
    logic                            aw_done_q;
    logic                            w_done_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                      resp_q;

    logic                            cmd_accept;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            b_hs;
    logic                            r_hs;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign aw_hs      = m_axi.awvalid && m_axi.awready;
    assign w_hs       = m_axi.wvalid  && m_axi.wready;
    assign b_hs       = m_axi.bvalid  && m_axi.bready;
    assign r_hs       = m_axi.rvalid  && m_axi.rready;

    // Next state and handshake outputs. Every VALID/READY is a pure function
    // of registered state, so no VALID ever depends on the slave's READY.
    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        m_axi.awvalid  = 1'b0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing looks acceptable
                // to the upstream during reset.
                cmd_ready = M_AXI_ARESETN;
                if (cmd_valid) begin
                    state_d = cmd_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                // AW and W retire independently; a channel already done
                // keeps its VALID low while the other one finishes.
                m_axi.awvalid = !aw_done_q;
                m_axi.wvalid  = !w_done_q;
                if ((aw_done_q || m_axi.awready) && (w_done_q || m_axi.wready)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    state_d = RSP;
                end
            end
            RD_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q <= state_d;

            if (cmd_accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                write_q   <= cmd_write;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end

            if (b_hs) begin
                resp_q  <= m_axi.bresp;
                rdata_q <= '0;
            end
            if (r_hs) begin
                resp_q  <= m_axi.rresp;
                rdata_q <= m_axi.rdata;
            end
        end
    end

    // Address/data come straight from the command latches, so they are
    // stable for the whole time their VALID is high.
    assign m_axi.awaddr = addr_q;
    assign m_axi.awprot = 3'b000;
    assign m_axi.wdata  = wdata_q;
    assign m_axi.wstrb  = wstrb_q;
    assign m_axi.araddr = addr_q;
    assign m_axi.arprot = 3'b000;

    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = write_q;
    assign busy      = (state_q != IDLE);

    riscv_axil_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .clear   (cmd_accept),
        .enable  (is_xfer_state(state_q)),
        .expired (timeout)
    );

endmodule

// File: tb/tb_riscv_axil_master.sv
// ---------------------------------------------------------------------------
// tb_riscv_axil_master
// Directed and randomized transactions against riscv_axil_master. Each
// transaction's expected bus timeline (when every VALID/READY is high, when
// the response appears, when the watchdog flag shows) is computed from the
// slave delays chosen for it; the slave drives its READY/VALID on exactly
// the cycles that timeline predicts.
// ---------------------------------------------------------------------------
module tb_riscv_axil_master;
    import riscv_axil_master_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit exp_to   = 1'b0;

    riscv_axil_master_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    riscv_axil_master #(
        .C_M_AXI_ADDR_WIDTH (4),
        .C_M_AXI_DATA_WIDTH (32),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_write     (rsp_write),
        .busy          (busy),
        .timeout       (timeout),
        .m_axi         (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
    endtask

    // One complete transaction. Delays are in cycles beyond the minimum.
    task automatic do_txn(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input logic [31:0] rd,
                          input logic [1:0] rs, input int rsp_d);
        int c_aw, c_w, c_wdone, c_b, c_ar, c_r, c_rsp, c_hs, ctr;
        logic [31:0] exp_rdata;
        c_aw = -1; c_w = -1; c_wdone = -1; c_b = -1; c_ar = -1; c_r = -1;
        if (wr) begin
            c_aw    = 1 + aw_d;
            c_w     = 1 + w_d;
            c_wdone = (c_aw > c_w) ? c_aw : c_w;
            c_b     = c_wdone + 1 + b_d;
            c_rsp   = c_b + 1;
        end else begin
            c_ar  = 1 + ar_d;
            c_r   = c_ar + 1 + r_d;
            c_rsp = c_r + 1;
        end
        c_hs      = c_rsp + rsp_d;
        exp_rdata = wr ? 32'h0 : rd;

        // cycle 0: present the command
        cyc       = 0;
        slave_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        chk("timeout_before_accept", timeout, exp_to);
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);

        for (int c = 1; c <= c_hs; c++) begin
            cyc = c;
            axi.awready = (c == c_aw);
            axi.wready  = (c == c_w);
            axi.bvalid  = (c == c_b);
            axi.bresp   = (c == c_b) ? rs : 2'($urandom);
            axi.arready = (c == c_ar);
            axi.rvalid  = (c == c_r);
            axi.rdata   = (c == c_r) ? rd : $urandom;
            axi.rresp   = (c == c_r) ? rs : 2'($urandom);
            rsp_ready   = (c == c_hs);

            chk("awvalid", axi.awvalid, wr && (c <= c_aw));
            chk("wvalid",  axi.wvalid,  wr && (c <= c_w));
            chk("bready",  axi.bready,  wr && (c > c_wdone) && (c <= c_b));
            chk("arvalid", axi.arvalid, !wr && (c <= c_ar));
            chk("rready",  axi.rready,  !wr && (c > c_ar) && (c <= c_r));
            chk("rsp_valid", rsp_valid, c >= c_rsp);
            chk("cmd_ready_busy", cmd_ready, 1'b0);
            chk("busy", busy, 1'b1);
            ctr = ((c < c_rsp) ? c : c_rsp) - 1;
            chk("timeout", timeout, ctr >= TO);
            if (wr && c <= c_aw) begin
                chk("awaddr", axi.awaddr, addr);
                chk("awprot", axi.awprot, 3'b000);
            end
            if (wr && c <= c_w) begin
                chk("wdata", axi.wdata, wd);
                chk("wstrb", axi.wstrb, ws);
            end
            if (!wr && c <= c_ar) begin
                chk("araddr", axi.araddr, addr);
                chk("arprot", axi.arprot, 3'b000);
            end
            if (c >= c_rsp) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp",  rsp_resp,  rs);
                chk("rsp_write", rsp_write, wr);
            end
            tick();
        end

        slave_idle();
        rsp_ready = 1'b0;
        cyc       = c_hs + 1;
        exp_to    = ((c_rsp - 1) >= TO);
        chk("rsp_valid_after_hs", rsp_valid, 1'b0);
        chk("busy_after_hs", busy, 1'b0);
        chk("cmd_ready_after_hs", cmd_ready, 1'b1);
        chk("timeout_after_hs", timeout, exp_to);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        slave_idle();

        // reset state
        #3;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp", rsp_resp, 2'b00);
        chk("rst_rsp_write", rsp_write, 1'b0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
        chk("rst_readies", {axi.bready, axi.rready}, 2'b00);
        chk("rst_awaddr", axi.awaddr, 4'h0);
        chk("rst_wdata", axi.wdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // minimum-latency write
        do_txn(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, RESP_OKAY, 0);
        // AW three cycles ahead of W, then W ahead of AW
        do_txn(1'b1, 4'h0, 32'hA5A5_0F0F, 4'h3, 0, 3, 0, 0, 0, 32'h0, RESP_OKAY, 0);
        do_txn(1'b1, 4'hC, 32'h1357_9BDF, 4'hC, 3, 0, 1, 0, 0, 32'h0, RESP_SLVERR, 0);
        // read with delayed RVALID
        do_txn(1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 5, 32'h12345678, RESP_OKAY, 0);
        // response held off by the consumer
        do_txn(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1, 0, 32'hCAFE_F00D, RESP_DECERR, 4);
        do_txn(1'b1, 4'h8, 32'h0BAD_BEEF, 4'h5, 1, 1, 0, 0, 0, 32'h0, RESP_EXOKAY, 2);
        // slave stalls B past the watchdog limit, then completes late
        do_txn(1'b1, 4'h0, 32'h0000_0001, 4'h1, 0, 0, 12, 0, 0, 32'h0, RESP_OKAY, 1);
        // flag clears on the next accept; an error response does not set it
        do_txn(1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h8765_4321, RESP_SLVERR, 0);

        // reset while waiting in the read-data phase
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'hC;
        cyc       = 0;
        tick();
        cmd_valid = 1'b0;
        cyc       = 1;
        chk("abort_arvalid", axi.arvalid, 1'b1);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        cyc         = 2;
        chk("abort_rready_before", axi.rready, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_rready", axi.rready, 1'b0);
        chk("abort_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready}, 4'b0000);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_release_cmd_ready", cmd_ready, 1'b1);
        chk("abort_release_busy", busy, 1'b0);
        // a stale R beat after the abort must not produce a response
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hFFFF_FFFF;
        tick();
        slave_idle();
        chk("abort_no_rsp", rsp_valid, 1'b0);
        chk("abort_still_idle", busy, 1'b0);
        exp_to = 1'b0;

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom), 4'($urandom_range(0, 3) << 2), $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 4), $urandom,
                   2'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
